// File: rtl/bip_control.sv
// bip_control: BIP accumulator CPU control unit.
// Program counter, opcode decode, start/run/halt FSM, instruction counter.
module bip_control #(
  parameter int NB_BITS    = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_CYCLES  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_BITS-1:0]    i_instr,
  output logic [NB_OPERAND-1:0] o_pc,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic [1:0]            o_sel_a,
  output logic                  o_sel_b,
  output logic                  o_op_code,
  output logic                  o_wr_acc,
  output logic                  o_wr_ram,
  output logic                  o_rd_ram,
  output logic                  o_done,
  output logic [NB_CYCLES-1:0]  o_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LDV  = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  state_t                  state;
  logic [NB_OPERAND-1:0]   pc;
  logic [NB_CYCLES-1:0]    cycles;
  logic                    done;
  logic [NB_OPCODE-1:0]    opcode;
  logic                    run;

  assign opcode    = i_instr[NB_BITS-1 -: NB_OPCODE];
  assign o_operand = i_instr[NB_OPERAND-1:0];
  assign o_pc      = pc;
  assign o_cycles  = cycles;
  assign o_done    = done;
  assign run       = (state == RUN);

  // FSM, program counter and saturating instruction counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      pc     <= '0;
      cycles <= '0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (i_start) begin
            state  <= RUN;
            pc     <= '0;
            cycles <= '0;
            done   <= 1'b0;
          end
        end
        RUN: begin
          if (cycles != '1)
            cycles <= cycles + NB_CYCLES'(1);
          if (opcode == OP_HLT) begin
            state <= HALT;
            done  <= 1'b1;
          end else begin
            pc <= pc + NB_OPERAND'(1);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Strobe decode; gated by RUN so reset drops strobes at once
  always_comb begin
    o_sel_a   = 2'b00;
    o_sel_b   = 1'b0;
    o_op_code = 1'b0;
    o_wr_acc  = 1'b0;
    o_wr_ram  = 1'b0;
    o_rd_ram  = 1'b0;
    unique case (1'b1)
      run && opcode == OP_STO: begin
        o_wr_ram = 1'b1;
      end
      run && opcode == OP_LDV: begin
        o_rd_ram = 1'b1;
        o_wr_acc = 1'b1;
      end
      run && opcode == OP_LDI: begin
        o_sel_a  = 2'b01;
        o_wr_acc = 1'b1;
      end
      run && opcode == OP_ADD: begin
        o_sel_a   = 2'b10;
        o_op_code = 1'b1;
        o_rd_ram  = 1'b1;
        o_wr_acc  = 1'b1;
      end
      run && opcode == OP_ADDI: begin
        o_sel_a   = 2'b10;
        o_sel_b   = 1'b1;
        o_op_code = 1'b1;
        o_wr_acc  = 1'b1;
      end
      run && opcode == OP_SUB: begin
        o_sel_a  = 2'b10;
        o_rd_ram = 1'b1;
        o_wr_acc = 1'b1;
      end
      run && opcode == OP_SUBI: begin
        o_sel_a  = 2'b10;
        o_sel_b  = 1'b1;
        o_wr_acc = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
